// File: rtl/serial_sub_16bit_pkg.sv
// serial_sub_16bit_pkg
// Shared definitions for the bit-serial subtractor slice: operand width,
// bit-counter width and FSM state encoding.
package serial_sub_16bit_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_16bit_if.sv
// serial_sub_16bit_if
// Request/response bundle between the control unit (master) and the
// bit-serial subtractor (slave).
//   start        request, sampled by the slave only in IDLE or DONE
//   X, Y, Bin    minuend, subtrahend, borrow-in (captured on accepted start)
//   D            difference (registered)
//   Bout, Ov     borrow-out of MSB, signed overflow
//   busy, done   operation in progress / one-cycle result-valid pulse
import serial_sub_16bit_pkg::*;

interface serial_sub_16bit_if;

  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Bin;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Ov;
  logic             busy;
  logic             done;

  modport master (
    output start, X, Y, Bin,
    input  D, Bout, Ov, busy, done
  );

  modport slave (
    input  start, X, Y, Bin,
    output D, Bout, Ov, busy, done
  );

endinterface

// File: rtl/serial_sub_16bit_fs.sv
// serial_sub_16bit_fs
// One-bit full subtractor cell: d = a - b - bin.
//   a, b, bin  minuend bit, subtrahend bit, borrow-in
//   d, bout    difference bit, borrow-out
module serial_sub_16bit_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow out when a < b, or when a == b and a borrow arrives from below.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_16bit.sv
// serial_sub_16bit
// Bit-serial WIDTH-bit subtractor, D = X - Y - Bin, processing one bit per
// clock through a single full-subtractor cell. Latency 17 cycles from the
// start edge to the done pulse; a start in the DONE cycle chains directly.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    serial_sub_16bit_if.slave (start/X/Y/Bin in, D/Bout/Ov/busy/done out)
module serial_sub_16bit
  import serial_sub_16bit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  serial_sub_16bit_if.slave   bus
);

  state_e           state_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] res_r;
  logic             b_r;
  logic             bmsb_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             ov_r;
  logic             busy_r;
  logic             done_r;
  logic             diff_s;
  logic             bnext_s;

  // Single shared subtractor cell working on the LSBs of the operand shifters.
  serial_sub_16bit_fs u_fs (
    .a    (x_r[0]),
    .b    (y_r[0]),
    .bin  (b_r),
    .d    (diff_s),
    .bout (bnext_s)
  );

  assign bus.D    = d_r;
  assign bus.Bout = bout_r;
  assign bus.Ov   = ov_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Control FSM, operand/result shifters and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      res_r   <= '0;
      b_r     <= 1'b0;
      bmsb_r  <= 1'b0;
      cnt_r   <= '0;
      d_r     <= '0;
      bout_r  <= 1'b0;
      ov_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            x_r     <= bus.X;
            y_r     <= bus.Y;
            b_r     <= bus.Bin;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
          res_r <= {diff_s, res_r[WIDTH-1:1]};
          x_r   <= {1'b0, x_r[WIDTH-1:1]};
          y_r   <= {1'b0, y_r[WIDTH-1:1]};
          b_r   <= bnext_s;
          cnt_r <= cnt_r + CNT_W'(1);
          // Borrow leaving bit WIDTH-2 is the borrow into the MSB; kept for Ov.
          if (cnt_r == CNT_W'(WIDTH - 2)) begin
            bmsb_r <= bnext_s;
          end
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            d_r     <= {diff_s, res_r[WIDTH-1:1]};
            bout_r  <= bnext_s;
            ov_r    <= bnext_s ^ bmsb_r;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_16bit.sv
// tb_serial_sub_16bit
// Directed-vector bench with a scoreboard queue: stimulus pushes the
// hand-computed result, a negedge monitor pops and compares on every done.
module tb_serial_sub_16bit;
  import serial_sub_16bit_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;
  int   done_count;
  int   cyc;
  int   t0;

  serial_sub_16bit_if bus ();

  serial_sub_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with D=0x%0h, expected no pending op", bus.D);
      end else begin
        e = sb_q.pop_front();
        check("D", 32'(bus.D), 32'(e.d));
        check("Bout", 32'(bus.Bout), 32'(e.bo));
        check("Ov", 32'(bus.Ov), 32'(e.ov));
      end
    end
  end

  // Present one request for one edge; optionally record its expected result.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic bin,
                       input logic [15:0] d, input logic bo, input logic ov,
                       input bit expect_result);
    bus.X     = x;
    bus.Y     = y;
    bus.Bin   = bin;
    bus.start = 1'b1;
    if (expect_result) sb_q.push_back('{d: d, bo: bo, ov: ov});
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; check busy and held D mid-operation and latency.
  task automatic wait_done(input string name, input logic [15:0] hold_d, input int pulse_at);
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = cyc - t0;
    while (!seen && lat < 40) begin
      if (lat == pulse_at) begin
        bus.X     = 16'hFFFF;
        bus.Y     = 16'h0000;
        bus.Bin   = 1'b1;
        bus.start = 1'b1;
      end
      if (lat == 8) begin
        check({name, "_busy"}, 32'(bus.busy), 32'd1);
        check({name, "_hold"}, 32'(bus.D), 32'(hold_d));
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = cyc - t0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({name, "_latency"}, 32'(lat), 32'd17);
  endtask

  task automatic check_zero(input string name);
    check({name, "_D"}, 32'(bus.D), 32'd0);
    check({name, "_Bout"}, 32'(bus.Bout), 32'd0);
    check({name, "_Ov"}, 32'(bus.Ov), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.done), 32'd0);
  endtask

  // Vectors: X, Y, Bin, expected D, Bout, Ov (hand-computed).
  logic [15:0] vx [5] = '{16'h0005, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000};
  logic [15:0] vy [5] = '{16'h0003, 16'h0001, 16'h0001, 16'hFFFF, 16'h0000};
  logic        vb [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] vd [5] = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
  logic        vbo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        vov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [15:0] last_d;
    int          t_first;
    int          dc;
    n_checks   = 0;
    n_fail     = 0;
    done_count = 0;
    cyc        = 0;
    t0         = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.X      = 16'h0000;
    bus.Y      = 16'h0000;
    bus.Bin    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n  = 1'b1;
    last_d = 16'h0000;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      issue(vx[i], vy[i], vb[i], vd[i], vbo[i], vov[i], 1'b1);
      wait_done($sformatf("vec%0d", i), last_d, -1);
      last_d = vd[i];
      repeat (2) @(posedge clk);
      #1;
    end

    // Back-to-back: second start presented during the DONE cycle.
    issue(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    t_first = t0;
    wait_done("b2b_first", last_d, -1);
    issue(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b1);
    wait_done("b2b_second", 16'hFFFF, -1);
    check("b2b_total_latency", 32'(cyc - t_first), 32'd34);
    repeat (3) @(posedge clk);
    #1;

    // Reset at cycle 8 of an operation: outputs clear, no done pulse.
    dc = done_count;
    issue(16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midrst");
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_count), 32'(dc));
    check("midrst_busy_idle", 32'(bus.busy), 32'd0);

    // Start pulsed during SHIFT must be ignored.
    dc = done_count;
    issue(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1);
    wait_done("ignore", 16'h0000, 5);
    repeat (25) @(posedge clk);
    #1;
    check("ignore_single_done", 32'(done_count), 32'(dc + 1));
    check("ignore_D_held", 32'(bus.D), 32'h00FF);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, expected end of test", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_sub_16bit.md
# serial_sub_16bit

Bit-serial 16-bit subtractor computing D = X − Y − Bin with a start/done handshake. It is the inverse-direction companion to the ripple-carry 16-bit adder in the datapath: same operand width, same flag semantics (borrow-out in place of carry-out, plus signed overflow). It trades latency for area by reusing one full-subtractor cell over 16 clock cycles. It sits beside the adder in the ALU and is driven by the control unit for SUB/CMP instructions.

## Interface
- WIDTH, 16, operand/result width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous and active-low
- start  input  1  request; sampled only in IDLE or DONE
- X  input  WIDTH  minuend; captured on accepted start
- Y  input  WIDTH  subtrahend; captured on accepted start
- Bin  input  1  borrow-in; captured on accepted start
- D  output  WIDTH  difference; registered
- Bout  output  1  borrow-out of MSB (1 ⇔ X < Y + Bin, unsigned)
- Ov  output  1  signed overflow (borrow into MSB XOR borrow out of MSB)
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when D/Bout/Ov are updated

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. Start=1 → latch X, Y into shift registers, borrow flop ← Bin, bit counter ← 0, go to SHIFT.
- SHIFT, each edge:
  - d = x0 ^ y0 ^ b
  - b' = (~x0 & y0) | (~(x0 ^ y0) & b)
  - d shifts into the MSB of the result shift register.
  - X and Y registers shift right.
  - Counter increments.
  - On the edge processing bit WIDTH−2, the borrow b' is saved as borrow-into-MSB.
  - After bit WIDTH−1 → DONE.
- Leaving SHIFT: output registers load D ← result, Bout ← final borrow, Ov ← Bout XOR saved borrow-into-MSB.
- DONE: done=1 for exactly one cycle. Start=1 here is accepted as in IDLE (back-to-back operation); otherwise → IDLE.
- start during SHIFT is ignored; operands in flight are unaffected.
- D, Bout, Ov hold their last values until the next completed operation. They do not change during SHIFT.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycles 1–16: busy=1.
- Cycle 17: done=1 with D/Bout/Ov valid. Latency is 17 cycles start-to-done.
- Throughput: one operation per 17 cycles with back-to-back start in DONE.
- Reset (rst_n=0 at an edge): state ← IDLE; D, Bout, Ov, busy, done ← 0; counter and borrow ← 0. This applies mid-operation too: the in-flight result is discarded and no done pulse is produced.
- Reset dominates a simultaneous start.

## Structure
- Shared package holds:
  - WIDTH default (16)
  - state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - counter width = $clog2(WIDTH)
- One sub-module: FS, a one-bit full subtractor (inputs a, b, bin; outputs d, bout). It mirrors the FA cell and is instantiated once.

## Test plan
- X=0x0005, Y=0x0003, Bin=0 → done at cycle 17; D=0x0002, Bout=0, Ov=0.
- X=0x0000, Y=0x0001, Bin=0 → D=0xFFFF, Bout=1, Ov=0.
- X=0x8000, Y=0x0001 → D=0x7FFF, Bout=0, Ov=1.
- X=0x7FFF, Y=0xFFFF → D=0x8000, Bout=1, Ov=1.
- X=0x1234, Y=0x1234, Bin=1 → D=0xFFFF, Bout=1, Ov=0. A second start asserted in the DONE cycle with X=0x0010, Y=0x0001 → done at cycle 34, D=0x000F.
- Start, then rst_n=0 at cycle 8 → all outputs 0, no done pulse. Separately, start pulsed at cycle 5 during busy → ignored; D equals the first operation's result.
